// File: rtl/ld_ext_pipe_pkg.sv
// Shared load-path control encodings: extension op and access size.
package ctrl_encode_def;

    localparam logic EXT_SIGNED = 1'b1;
    localparam logic EXT_ZERO   = 1'b0;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

endpackage

// File: rtl/ld_ext_lane.sv
// Combinational lane extractor: masks the byte offset to the access size,
// selects the addressed byte/half/word and sign- or zero-extends it.
// Optional misalignment flag when LD_EXT_MISALIGN_CHK_EN is defined.
module ld_ext_lane
    import ctrl_encode_def::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              extop,
    output logic [DATA_W-1:0] res,
    output logic              err
);

    size_e             sz;
    logic [OFF_W-1:0]  eff_off;
    logic [31:0]       lane;
    logic              fill;

    assign sz = size_e'(size);

    // Offset masking, lane select and extension of the selected field.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        eff_off = off;
        lane    = '0;
        fill    = 1'b0;
        res     = '0;
        case (sz)
            SZ_BYTE: eff_off = off;
            SZ_HALF: eff_off = off & ~OFF_W'(1);
            default: eff_off = off & ~OFF_W'(3);   // word and reserved
        endcase
        lane = 32'(data >> {eff_off, 3'b000});
        case (sz)
            SZ_BYTE: begin
                fill      = (extop == EXT_SIGNED) && lane[7];
                res       = {DATA_W{fill}};
                res[7:0]  = lane[7:0];
            end
            SZ_HALF: begin
                fill      = (extop == EXT_SIGNED) && lane[15];
                res       = {DATA_W{fill}};
                res[15:0] = lane[15:0];
            end
            default: begin
                fill      = (extop == EXT_SIGNED) && lane[31];
                res       = {DATA_W{fill}};
                res[31:0] = lane;
            end
        endcase
    end

`ifdef LD_EXT_MISALIGN_CHK_EN
    assign err = ((sz == SZ_HALF) && off[0])
              || ((sz == SZ_WORD) && (off[1:0] != 2'b00))
              ||  (sz == SZ_RSVD);
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/ld_ext_pipe.sv
// Registered load extender: lane extraction followed by a main register
// and a one-entry skid register behind valid/ready handshakes.
// in_ready is registered (= !valid_s) and never depends on out_ready.
// Optional macro: LD_EXT_MISALIGN_CHK_EN enables out_err reporting.
module ld_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_extop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [DATA_W-1:0] lane_data;
    logic              lane_err;

    logic              valid_m, valid_s, ready_q;
    logic [DATA_W-1:0] data_m, data_s;
    logic              err_m, err_s;

    logic              valid_m_nxt, valid_s_nxt;
    logic [DATA_W-1:0] data_m_nxt, data_s_nxt;
    logic              err_m_nxt, err_s_nxt;

    logic              accept, drain;

    ld_ext_lane #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_lane (
        .data  (in_data),
        .off   (in_off),
        .size  (in_size),
        .extop (in_extop),
        .res   (lane_data),
        .err   (lane_err)
    );

    assign accept = in_valid && ready_q;
    assign drain  = valid_m && out_ready;

    // Next-state for main/skid: refill main from skid first, else from input.
    always_comb begin
        valid_m_nxt = valid_m;
        valid_s_nxt = valid_s;
        data_m_nxt  = data_m;
        data_s_nxt  = data_s;
        err_m_nxt   = err_m;
        err_s_nxt   = err_s;
        if (!valid_m || drain) begin
            if (valid_s) begin
                // in_ready is low whenever the skid is full, so no accept here.
                valid_m_nxt = 1'b1;
                data_m_nxt  = data_s;
                err_m_nxt   = err_s;
                valid_s_nxt = 1'b0;
            end else if (accept) begin
                valid_m_nxt = 1'b1;
                data_m_nxt  = lane_data;
                err_m_nxt   = lane_err;
            end else begin
                valid_m_nxt = 1'b0;
            end
        end else if (accept) begin
            valid_s_nxt = 1'b1;
            data_s_nxt  = lane_data;
            err_s_nxt   = lane_err;
        end
    end

    // State registers with synchronous reset; in_ready tracks the next skid state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: data registers are reset too, because out_data/out_err must read 0 during reset.
            valid_m <= 1'b0;
            valid_s <= 1'b0;
            ready_q <= 1'b0;
            data_m  <= '0;
            data_s  <= '0;
            err_m   <= 1'b0;
            err_s   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            valid_m <= valid_m_nxt;
            valid_s <= valid_s_nxt;
            ready_q <= !valid_s_nxt;
            data_m  <= data_m_nxt;
            data_s  <= data_s_nxt;
            err_m   <= err_m_nxt;
            err_s   <= err_s_nxt;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_m;
    assign out_data  = data_m;
    assign out_err   = err_m;

endmodule
